aes128_inv_fsm: RTL and testbench

AES-128 decryption engine: the inverse cipher counterpart to the encrypt FSM, sharing its start/ready/valid handshake and byte ordering. Takes a 128-bit ciphertext and cipher key, derives the final round key, then runs the ten inverse rounds byte-serially using one forward S-box (key schedule) and one inverse S-box (InvSubBytes). Sits alongside the encrypt FSM behind the peripheral register interface.

---
 rtl/aes128_inv_fsm.sv | 269 ++++++++++++++++++++++++++
 tb/tb_aes128_inv_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_fsm.sv
// rtl/aes128_inv_fsm.sv - byte-serial AES-128 inverse cipher FSM
// Purpose: decrypts one 128-bit block with a 128-bit key. The final round key
//   is derived forward first, then the ten inverse rounds run one byte per
//   cycle while the key schedule is unwound backwards alongside them.
// Ports:
//   clk_i     clock, all state on rising edge
//   rst_n_i   asynchronous active-low reset
//   start_i   request, accepted only while ready_o is high
//   key_i     cipher key (round key 0), sampled at accept
//   data_i    ciphertext, sampled at accept; [127:120] is state byte 0
//   result_o  plaintext, held until the next completion
//   valid_o   result_o valid; set at completion, cleared on next accept
//   ready_o   idle and able to accept
module aes128_inv_fsm (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] result_o,
  output logic         valid_o,
  output logic         ready_o
);

  localparam logic [3:0] S_WAIT     = 4'd0;
  localparam logic [3:0] S_KEY_FWD  = 4'd1;
  localparam logic [3:0] S_INIT_ARK = 4'd2;
  localparam logic [3:0] S_ISR      = 4'd3;
  localparam logic [3:0] S_ISB      = 4'd4;
  localparam logic [3:0] S_KEY_BACK = 4'd5;
  localparam logic [3:0] S_ARK      = 4'd6;
  localparam logic [3:0] S_IMC      = 4'd7;
  localparam logic [3:0] S_STORE    = 4'd8;

  logic [3:0]   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] snap_q, snap_d;
  logic [127:0] result_q, result_d;
  logic [31:0]  sub_q, sub_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   byte_q, byte_d;
  logic [3:0]   kstep_q, kstep_d;
  logic         valid_q, valid_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State byte n sits at bits [127-8n -: 8]; ~n*8 gives the low bit index.
  function automatic logic [7:0] pick(input logic [127:0] v, input logic [3:0] idx);
    return v[{~idx, 3'b000} +: 8];
  endfunction

  // Row r of column c is byte 4c+r; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  logic [31:0]  sb_word;
  logic [1:0]   rot_idx;
  logic [7:0]   sb_in, sb_out, isb_out, mix_out, rc;
  logic [4:0]   sub_lo;
  logic [6:0]   st_lo;
  logic [1:0]   mc_col, mc_row;
  logic [31:0]  w0_new, kf_w1, kf_w2, kf_w3;

  // Forward S-box serves the key schedule only: old w3 going forward,
  // recovered w3 (w3^w2) going backward.
  assign sb_word = (state_q == S_KEY_FWD)  ? rk_q[31:0] :
                   (state_q == S_KEY_BACK) ? (rk_q[31:0] ^ rk_q[63:32]) : 32'h0;
  assign rot_idx = byte_q[1:0] + 2'd1;  // RotWord: slot j takes byte j+1
  assign sb_in   = sb_word[{~rot_idx, 3'b000} +: 8];
  assign sb_out  = sbox_fwd(sb_in);
  assign sub_lo  = {~byte_q[1:0], 3'b000};
  assign st_lo   = {~byte_q, 3'b000};
  assign isb_out = sbox_inv(pick(st_q, byte_q));
  assign rc      = rcon((state_q == S_KEY_FWD) ? kstep_q : round_q);

  // w0 update has the same form in both directions.
  assign w0_new  = rk_q[127:96] ^ sub_q ^ {rc, 24'h0};
  assign kf_w1   = rk_q[95:64] ^ w0_new;
  assign kf_w2   = rk_q[63:32] ^ kf_w1;
  assign kf_w3   = rk_q[31:0] ^ kf_w2;

  assign mc_col  = byte_q[3:2];
  assign mc_row  = byte_q[1:0];
  assign mix_out = gf_mul(pick(snap_q, {mc_col, mc_row}),         8'h0e) ^
                   gf_mul(pick(snap_q, {mc_col, mc_row + 2'd1}),  8'h0b) ^
                   gf_mul(pick(snap_q, {mc_col, mc_row + 2'd2}),  8'h0d) ^
                   gf_mul(pick(snap_q, {mc_col, mc_row + 2'd3}),  8'h09);

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rk_d     = rk_q;
    snap_d   = snap_q;
    result_d = result_q;
    sub_d    = sub_q;
    round_d  = round_q;
    byte_d   = byte_q;
    kstep_d  = kstep_q;
    valid_d  = valid_q;
    case (state_q)
      S_WAIT: begin
        if (start_i) begin
          st_d    = data_i;
          rk_d    = key_i;
          valid_d = 1'b0;
          round_d = 4'd0;
          byte_d  = 4'd0;
          kstep_d = 4'd0;
          state_d = S_KEY_FWD;
        end
      end
      S_KEY_FWD: begin
        if (byte_q == 4'd4) begin
          rk_d   = {w0_new, kf_w1, kf_w2, kf_w3};
          byte_d = 4'd0;
          if (kstep_q == 4'd9) begin
            kstep_d = 4'd0;
            state_d = S_INIT_ARK;
          end else begin
            kstep_d = kstep_q + 4'd1;
          end
        end else begin
          sub_d[sub_lo +: 8] = sb_out;
          byte_d = byte_q + 4'd1;
        end
      end
      S_INIT_ARK: begin
        st_d    = st_q ^ rk_q;
        round_d = 4'd9;
        state_d = S_ISR;
      end
      S_ISR: begin
        st_d    = inv_shift_rows(st_q);
        state_d = S_ISB;
      end
      S_ISB: begin
        st_d[st_lo +: 8] = isb_out;
        byte_d = byte_q + 4'd1;
        if (byte_q == 4'd15) state_d = S_KEY_BACK;
      end
      S_KEY_BACK: begin
        if (byte_q == 4'd4) begin
          rk_d    = {w0_new, rk_q[127:96] ^ rk_q[95:64],
                     rk_q[95:64] ^ rk_q[63:32], rk_q[63:32] ^ rk_q[31:0]};
          byte_d  = 4'd0;
          state_d = S_ARK;
        end else begin
          sub_d[sub_lo +: 8] = sb_out;
          byte_d = byte_q + 4'd1;
        end
      end
      S_ARK: begin
        st_d = st_q ^ rk_q;
        if (round_q == 4'd0) begin
          state_d = S_STORE;
        end else begin
          snap_d  = st_q ^ rk_q;  // column inputs frozen for the serial mix
          state_d = S_IMC;
        end
      end
      S_IMC: begin
        st_d[st_lo +: 8] = mix_out;
        byte_d = byte_q + 4'd1;
        if (byte_q == 4'd15) begin
          round_d = round_q - 4'd1;
          state_d = S_ISR;
        end
      end
      S_STORE: begin
        result_d = st_q;
        valid_d  = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_WAIT;
      st_q     <= '0;
      rk_q     <= '0;
      snap_q   <= '0;
      result_q <= '0;
      sub_q    <= '0;
      round_q  <= '0;
      byte_q   <= '0;
      kstep_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      rk_q     <= rk_d;
      snap_q   <= snap_d;
      result_q <= result_d;
      sub_q    <= sub_d;
      round_q  <= round_d;
      byte_q   <= byte_d;
      kstep_q  <= kstep_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign ready_o  = (state_q == S_WAIT);

endmodule

// File: tb/tb_aes128_inv_fsm.sv
// tb/tb_aes128_inv_fsm.sv - self-checking bench for aes128_inv_fsm
module tb_aes128_inv_fsm;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] data_i;
  logic [127:0] result_o;
  logic         valid_o;
  logic         ready_o;

  always #5 clk_i = ~clk_i;

  aes128_inv_fsm dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start_i),
    .key_i    (key_i),
    .data_i   (data_i),
    .result_o (result_o),
    .valid_o  (valid_o),
    .ready_o  (ready_o)
  );

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int LAT = 426;

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_t [256];
  vec_t tbl [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator walk: p steps through powers of 3,
  // q through powers of 3^-1, so q = p^-1 at every step.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Reference forward cipher on a byte array, state index 4*col+row.
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 10) ? t[4*c+r] :
                     xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4] ^
                     t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Waits (bounded) for valid_o; meanwhile scrambles key/data and, when asked,
  // pulses start_i. quiet drops if ready_o rises or result_o moves early.
  task automatic wait_valid(input bit pulses, input logic [127:0] hold,
                            output int cyc, output bit quiet);
    bit done;
    cyc   = 0;
    quiet = 1'b1;
    done  = 1'b0;
    while (cyc < 600 && !done) begin
      @(negedge clk_i);
      if (pulses) start_i = (cyc == 5 || cyc == 100 || cyc == 300);
      key_i  = {$urandom, $urandom, $urandom, $urandom};
      data_i = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk_i);
      #1;
      cyc++;
      if (valid_o) done = 1'b1;
      else if (ready_o || result_o !== hold) quiet = 1'b0;
    end
    if (pulses) start_i = 1'b0;
  endtask

  task automatic run(input logic [127:0] k, input logic [127:0] d, input logic [127:0] exp,
                     input bit pulses, input string nm);
    int cyc;
    bit quiet;
    logic [127:0] hold;
    @(negedge clk_i);
    start_i = 1'b1;
    key_i   = k;
    data_i  = d;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    hold    = result_o;
    chk({nm, " busy after accept"}, {126'd0, valid_o, ready_o}, 128'd0);
    wait_valid(pulses, hold, cyc, quiet);
    chk({nm, " latency"}, 128'(cyc), 128'(LAT));
    chk({nm, " valid"}, {127'd0, valid_o}, 128'd1);
    chk({nm, " result"}, result_o, exp);
    chk({nm, " quiet while busy"}, {127'd0, quiet}, 128'd1);
  endtask

  initial begin
    int cyc;
    bit quiet;
    logic [127:0] k, pt;

    build_sbox();
    tbl[0] = '{key: C1_KEY, data: C1_CT, exp: C1_PT};
    tbl[1] = '{key: B_KEY,  data: B_CT,  exp: B_PT};

    rst_n_i = 1'b0;
    start_i = 1'b0;
    key_i   = '0;
    data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset result", result_o, 128'd0);
    chk("reset valid", {127'd0, valid_o}, 128'd0);
    chk("reset ready", {127'd0, ready_o}, 128'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 2; i++) run(tbl[i].key, tbl[i].data, tbl[i].exp, 1'b0, "vector");

    run(C1_KEY, C1_CT, C1_PT, 1'b1, "start pulses");

    // Back-to-back: start_i stays high from accept through completion.
    @(negedge clk_i);
    start_i = 1'b1;
    key_i   = C1_KEY;
    data_i  = C1_CT;
    @(posedge clk_i);
    #1;
    wait_valid(1'b0, result_o, cyc, quiet);
    key_i  = B_KEY;
    data_i = B_CT;
    chk("b2b first latency", 128'(cyc), 128'(LAT));
    chk("b2b first result", result_o, C1_PT);
    chk("b2b ready at completion", {127'd0, ready_o}, 128'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("b2b valid drop", {126'd0, valid_o, ready_o}, 128'd0);
    chk("b2b result held", result_o, C1_PT);
    wait_valid(1'b0, C1_PT, cyc, quiet);
    chk("b2b second latency", 128'(cyc), 128'(LAT));
    chk("b2b second result", result_o, B_PT);
    chk("b2b hold until done", {127'd0, quiet}, 128'd1);

    // Asynchronous reset partway through a run.
    @(negedge clk_i);
    start_i = 1'b1;
    key_i   = C1_KEY;
    data_i  = C1_CT;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (200) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrun reset result", result_o, 128'd0);
    chk("midrun reset valid", {127'd0, valid_o}, 128'd0);
    chk("midrun reset ready", {127'd0, ready_o}, 128'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run(C1_KEY, C1_CT, C1_PT, 1'b0, "after reset");

    for (int n = 0; n < 50; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      run(k, aes_enc(k, pt), pt, 1'b0, "round trip");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
